// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: applies up to STEP bit positions per clock
// until the requested amount is consumed, then pulses done with the result.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               abort,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               op_err,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W:0] STEP_V = (SHAMT_W + 1)'(STEP);

    state_t             state;
    state_t             state_next;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] remaining;
    logic               err_q;
    logic [SHAMT_W:0]   step_amt;
    logic [WIDTH-1:0]   shifted;
    logic               last_step;
    logic               op_illegal;
    logic               skip_shift;

    function automatic logic [WIDTH-1:0] shift_by(input logic [2:0] kind,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic [SHAMT_W:0] s);
        logic signed [WIDTH-1:0] sv;
        logic [WIDTH-1:0]        res;
        int                      n;
        int                      r;
        sv  = v;
        n   = int'(s);
        r   = n % WIDTH;
        res = v;
        // Rotates use r==0 safely: a shift by WIDTH yields zero, leaving v intact.
        case (kind)
            3'd0:    res = v >> n;
            3'd1:    res = sv >>> n;
            3'd2:    res = v << n;
            3'd3:    res = (v >> r) | (v << (WIDTH - r));
            3'd4:    res = (v << r) | (v >> (WIDTH - r));
            default: res = v;
        endcase
        return res;
    endfunction

    assign op_illegal = (op > 3'd4);
    assign skip_shift = (amount == '0) || op_illegal;
    assign step_amt   = ({1'b0, remaining} < STEP_V) ? {1'b0, remaining} : STEP_V;
    assign last_step  = ({1'b0, remaining} <= STEP_V);
    assign shifted    = shift_by(op_q, work, step_amt);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        op_err     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = skip_shift ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // abort takes priority over a completing step
                if (abort) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                op_err     = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q      <= '0;
            work      <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        work      <= operand;
                        remaining <= amount;
                        err_q     <= op_illegal;
                        if (skip_shift) begin
                            result <= operand;
                        end
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        work      <= shifted;
                        remaining <= remaining - step_amt[SHAMT_W-1:0];
                        if (last_step) begin
                            result <= shifted;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: two instances (STEP=1 and STEP=8) share
// stimulus; a monitor per instance checks result, op_err and done timing.
module tb_shift_sequencer;

    logic        clk     = 1'b0;
    logic        clr     = 1'b1;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [31:0] operand = 32'd0;
    logic [4:0]  amount  = 5'd0;

    logic        rdy1, bsy1, dn1, err1;
    logic [31:0] res1;
    logic        rdy8, bsy8, dn8, err8;
    logic [31:0] res8;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t e1, e8;
    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
        .clock(clk), .clear(clr), .start(start), .op(op), .operand(operand),
        .amount(amount), .abort(abort), .ready(rdy1), .busy(bsy1), .done(dn1),
        .op_err(err1), .result(res1)
    );

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) u8 (
        .clock(clk), .clear(clr), .start(start), .op(op), .operand(operand),
        .amount(amount), .abort(abort), .ready(rdy8), .busy(bsy8), .done(dn8),
        .op_err(err8), .result(res8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dn1 === 1'b1) begin
            if (q1.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL u1_unexpected_done: got done with result 0x%h, want no done", res1);
            end else begin
                e1 = q1.pop_front();
                check("u1_result", res1, e1.res);
                check("u1_op_err", {31'b0, err1}, {31'b0, e1.err});
                check("u1_done_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (dn8 === 1'b1) begin
            if (q8.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL u8_unexpected_done: got done with result 0x%h, want no done", res8);
            end else begin
                e8 = q8.pop_front();
                check("u8_result", res8, e8.res);
                check("u8_op_err", {31'b0, err8}, {31'b0, e8.err});
                check("u8_done_cycle", cyc, e8.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] v, input logic [4:0] a,
                         input logic [31:0] r, input logic e, input bit p1, input bit p8);
        int n = 0;
        int k;
        while (!(rdy1 && rdy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(rdy1 && rdy8)) begin
            vecs++;
            errs++;
            $display("FAIL ready_timeout: got ready %b/%b, want 1/1", rdy1, rdy8);
        end
        op      = o;
        operand = v;
        amount  = a;
        start   = 1'b1;
        k       = cyc + 1;
        if (p1) q1.push_back('{r, e, k + (e ? 0 : int'(a))});
        if (p8) q8.push_back('{r, e, k + (e ? 0 : (int'(a) + 7) / 8)});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #3;
        check("rst_result_u1", res1, 32'h0);
        check("rst_result_u8", res8, 32'h0);
        check("rst_done_busy_err", {29'b0, dn1 | dn8, bsy1 | bsy8, err1 | err8}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {30'b0, rdy1, rdy8}, 32'h3);

        // SHR by 4, busy duration on the single-step instance
        issue(3'd0, 32'hA5A5A5A5, 5'd4, 32'h0A5A5A5A, 1'b0, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bsy1) n++;
            @(negedge clk);
        end
        check("u1_busy_cycles", n, 32'd4);

        issue(3'd1, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
        issue(3'd2, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
        issue(3'd3, 32'hDEADBEEF, 5'd3,  32'hFBD5B7DD, 1'b0, 1'b1, 1'b1);
        issue(3'd4, 32'h12345678, 5'd8,  32'h34567812, 1'b0, 1'b1, 1'b1);
        issue(3'd2, 32'h87654321, 5'd16, 32'h43210000, 1'b0, 1'b1, 1'b1);
        issue(3'd7, 32'hCAFEF00D, 5'd5,  32'hCAFEF00D, 1'b1, 1'b1, 1'b1);

        // Ignored start and abort on u1; u8 finishes early and takes the second request
        issue(3'd0, 32'h12345678, 5'd8, 32'h00123456, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        op      = 3'd2;
        operand = 32'hFFFF0000;
        amount  = 5'd4;
        start   = 1'b1;
        q8.push_back('{32'hFFF00000, 1'b0, cyc + 2});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready_u1", {31'b0, rdy1}, 32'h1);
        check("abort_busy_u1", {31'b0, bsy1}, 32'h0);
        check("abort_result_held_u1", res1, 32'hCAFEF00D);
        repeat (12) @(negedge clk);

        // clear in the middle of a shift
        issue(3'd0, 32'hF0F0F0F0, 5'd20, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clear_result_u1", res1, 32'h0);
        check("clear_result_u8", res8, 32'h0);
        check("clear_done_busy", {28'b0, dn1, dn8, bsy1, bsy8}, 32'h0);
        check("clear_ready", {30'b0, rdy1, rdy8}, 32'h3);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        issue(3'd3, 32'h00000001, 5'd1, 32'h80000000, 1'b0, 1'b1, 1'b1);

        n = 0;
        while ((q1.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q8.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL done_timeout: got %0d/%0d pending, want 0/0", q1.size(), q8.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
